// File: rtl/draw_arbiter_if.sv
// Pixel-merge bus between the sprite/HUD drawers and the VGA write port.
// Client-side fields are packed per client: element i belongs to client i.
interface draw_arbiter_if #(
  parameter int X_W = 8,
  parameter int Y_W = 7,
  parameter int C_W = 3,
  parameter int N   = 4
);
  logic [N-1:0]          req;
  logic [N-1:0][X_W-1:0] x_in;
  logic [N-1:0][Y_W-1:0] y_in;
  logic [N-1:0][C_W-1:0] colour_in;
  logic [N-1:0]          write_in;
  logic [N-1:0]          enable_out;
  logic [X_W-1:0]        x;
  logic [Y_W-1:0]        y;
  logic [C_W-1:0]        colour;
  logic                  plot;
  logic                  busy;

  modport master (
    output req, x_in, y_in, colour_in, write_in,
    input  enable_out, x, y, colour, plot, busy
  );

  modport slave (
    input  req, x_in, y_in, colour_in, write_in,
    output enable_out, x, y, colour, plot, busy
  );
endinterface

// File: rtl/draw_arbiter.sv
// Round-robin merge of 4 drawer pixel streams onto the single vga_adapter port.
// Optional per-grant hold limit: define DRAW_ARB_TIMEOUT_EN (limit = MAX_HOLD).
module draw_arbiter #(
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int C_W      = 3,
  parameter int MAX_HOLD = 256
) (
  input  logic            clk,
  input  logic            resetn,
  draw_arbiter_if.slave   bus
);
  localparam int N = 4;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t         state_q, state_d;
  logic [1:0]     sel_q, sel_d;
  logic [1:0]     last_q, last_d;
  logic [N-1:0]   enable_q, enable_d;
  logic [X_W-1:0] x_q, x_d;
  logic [Y_W-1:0] y_q, y_d;
  logic [C_W-1:0] colour_q, colour_d;
  logic           plot_q, plot_d;
  logic           busy_q, busy_d;

  logic [1:0]     pick, cand;
  logic           found;
  logic           timeout;

`ifdef DRAW_ARB_TIMEOUT_EN
  localparam int CNT_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  logic [CNT_W-1:0] hold_q, hold_d;

  assign timeout = (hold_q == CNT_W'(MAX_HOLD - 1));

  always_comb begin
    hold_d = hold_q;
    if (state_q == IDLE) hold_d = '0;
    else                 hold_d = hold_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!resetn) hold_q <= '0;
    else         hold_q <= hold_d;
  end
`else
  // No counter in this build: grants are unbounded, MAX_HOLD is inert.
  assign timeout = 1'b0 && (MAX_HOLD > 0);
`endif

  // Search starts one past the last released client so everyone gets a turn.
  always_comb begin
    pick  = 2'd0;
    cand  = 2'd0;
    found = 1'b0;
    for (int k = 1; k <= N; k++) begin
      cand = last_q + 2'(k);
      if (!found && bus.req[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    last_d   = last_q;
    enable_d = enable_q;
    x_d      = x_q;
    y_d      = y_q;
    colour_d = colour_q;
    plot_d   = plot_q;
    busy_d   = busy_q;
    case (state_q)
      IDLE: begin
        plot_d = 1'b0;
        if (found) begin
          sel_d    = pick;
          enable_d = 4'(1) << pick;
          busy_d   = 1'b1;
          state_d  = BUSY;
        end
      end
      BUSY: begin
        // enable already low in BUSY means the hold limit cut this grant last cycle
        if (enable_q != '0 && bus.req[sel_q]) begin
          x_d      = bus.x_in[sel_q];
          y_d      = bus.y_in[sel_q];
          colour_d = bus.colour_in[sel_q];
          plot_d   = bus.write_in[sel_q];
          if (timeout) enable_d = '0;
        end else begin
          enable_d = '0;
          plot_d   = 1'b0;
          busy_d   = 1'b0;
          last_d   = sel_q;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= IDLE;
      sel_q    <= 2'd0;
      last_q   <= 2'd3;
      enable_q <= '0;
      x_q      <= '0;
      y_q      <= '0;
      colour_q <= '0;
      plot_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      last_q   <= last_d;
      enable_q <= enable_d;
      x_q      <= x_d;
      y_q      <= y_d;
      colour_q <= colour_d;
      plot_q   <= plot_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.enable_out = enable_q;
  assign bus.x          = x_q;
  assign bus.y          = y_q;
  assign bus.colour     = colour_q;
  assign bus.plot       = plot_q;
  assign bus.busy       = busy_q;
endmodule

// File: tb/tb_draw_arbiter.sv
// Bench for draw_arbiter: queue-driven drawer clients, a transaction-level
// arbitration model, and per-cycle comparison of every VGA-side output.
module tb_draw_arbiter;
  localparam int X_W = 8, Y_W = 7, C_W = 3, N = 4, MAX_HOLD = 8;
  localparam int OW = N + 2 + X_W + Y_W + C_W;
  localparam int LIMIT = 3000;

  typedef struct packed {
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    logic [C_W-1:0] c;
    logic           w;
  } pix_t;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  draw_arbiter_if #(.X_W(X_W), .Y_W(Y_W), .C_W(C_W), .N(N)) bus();

  draw_arbiter #(.X_W(X_W), .Y_W(Y_W), .C_W(C_W), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .resetn(resetn), .bus(bus.slave)
  );

  pix_t cq [N][$];
  int   glog[$];
  int   tests = 0, fails = 0, plots = 0;
  logic [N-1:0] prev_en = '0;

  // model: who owns the port, who was released last, captured pixel
  int             m_owner, m_last, m_cnt;
  bit             m_cut;
  logic [X_W-1:0] m_x;
  logic [Y_W-1:0] m_y;
  logic [C_W-1:0] m_c;
  logic           m_plot;

  function automatic logic [N-1:0] m_en();
    if (m_owner >= 0 && !m_cut) return 4'(1) << m_owner;
    return '0;
  endfunction

  function automatic bit all_idle();
    for (int i = 0; i < N; i++) if (cq[i].size() > 0) return 1'b0;
    return m_owner < 0;
  endfunction

  task automatic model_update();
    if (!resetn) begin
      m_owner = -1; m_last = 3; m_cut = 0; m_cnt = 0;
      m_x = '0; m_y = '0; m_c = '0; m_plot = 1'b0;
    end else if (m_owner < 0) begin
      m_plot = 1'b0;
      for (int k = 1; k <= N; k++)
        if (m_owner < 0 && bus.req[(m_last + k) % N]) begin
          m_owner = (m_last + k) % N; m_cnt = 0; m_cut = 0;
        end
    end else if (m_cut || !bus.req[m_owner]) begin
      m_plot = 1'b0; m_last = m_owner; m_owner = -1; m_cut = 0;
    end else begin
      m_x = bus.x_in[m_owner]; m_y = bus.y_in[m_owner];
      m_c = bus.colour_in[m_owner]; m_plot = bus.write_in[m_owner];
`ifdef DRAW_ARB_TIMEOUT_EN
      if (m_cnt == MAX_HOLD - 1) m_cut = 1;
`endif
      m_cnt++;
    end
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < N; i++) begin
      if (cq[i].size() > 0) begin
        bus.req[i] = 1'b1;
        bus.x_in[i] = cq[i][0].x; bus.y_in[i] = cq[i][0].y;
        bus.colour_in[i] = cq[i][0].c; bus.write_in[i] = cq[i][0].w;
      end else begin
        bus.req[i] = 1'b0;
        bus.x_in[i] = X_W'($urandom); bus.y_in[i] = Y_W'($urandom);
        bus.colour_in[i] = C_W'($urandom); bus.write_in[i] = 1'($urandom);
      end
    end
  endtask

  task automatic step(output logic [OW-1:0] obs, output logic [OW-1:0] expv);
    logic [N-1:0] en_seen;
    @(negedge clk);
    obs  = {bus.enable_out, bus.busy, bus.plot, bus.x, bus.y, bus.colour};
    expv = {m_en(), 1'(m_owner >= 0), m_plot, m_x, m_y, m_c};
    en_seen = bus.enable_out;
    if (prev_en == '0 && en_seen != '0)
      for (int i = 0; i < N; i++) if (en_seen[i]) glog.push_back(i);
    prev_en = en_seen;
    if (bus.plot === 1'b1) plots++;
    @(posedge clk);
    model_update();
    if (resetn)
      for (int i = 0; i < N; i++)
        if (en_seen[i] && bus.req[i] && cq[i].size() > 0) void'(cq[i].pop_front());
    #1 drive_inputs();
  endtask

  task automatic load(input int cl, input int n);
    pix_t p;
    for (int k = 0; k < n; k++) begin
      p.x = X_W'($urandom); p.y = Y_W'($urandom); p.c = C_W'($urandom); p.w = 1'b1;
      cq[cl].push_back(p);
    end
  endtask

  task automatic reset_dut();
    logic [OW-1:0] o, e;
    for (int i = 0; i < N; i++) cq[i].delete();
    drive_inputs();
    resetn = 1'b0;
    step(o, e); step(o, e);
    resetn = 1'b1;
    glog.delete(); plots = 0;
  endtask

  task automatic test_reset();
    logic [OW-1:0] o, e;
    reset_dut();
    step(o, e);
    tests++;
    if (o !== '0) begin fails++; $display("FAIL reset_state obs=%h exp=0", o); end
    tests++;
    if (o !== e) begin fails++; $display("FAIL reset_model obs=%h exp=%h", o, e); end
  endtask

  task automatic test_single_stream();
    logic [OW-1:0] o, e;
    pix_t p;
    bit bad = 0;
    reset_dut();
    for (int yy = 87; yy <= 98; yy++)
      for (int xx = 146; xx <= 149; xx++) begin
        p.x = X_W'(xx); p.y = Y_W'(yy); p.c = C_W'($urandom); p.w = 1'b1;
        cq[0].push_back(p);
      end
    drive_inputs();
    for (int c = 0; c < LIMIT && !all_idle(); c++) begin
      step(o, e); tests++;
      if (o !== e) begin fails++; $display("FAIL stream cyc%0d obs=%h exp=%h", c, o, e); end
    end
    step(o, e); tests++;
    if (o !== e || !all_idle()) begin fails++; $display("FAIL stream_end obs=%h exp=%h", o, e); end
    tests++;
    if (plots != 48) begin fails++; $display("FAIL stream_plots got=%0d want=48", plots); end
    foreach (glog[i]) if (glog[i] != 0) bad = 1;
    tests++;
    if (bad || glog.size() == 0) begin fails++; $display("FAIL stream_owner grants=%0d", glog.size()); end
  endtask

  task automatic test_simultaneous();
    logic [OW-1:0] o, e;
    reset_dut();
    load(1, 5); load(3, 5); drive_inputs();
    for (int c = 0; c < LIMIT && !all_idle(); c++) begin
      step(o, e); tests++;
      if (o !== e) begin fails++; $display("FAIL simul cyc%0d obs=%h exp=%h", c, o, e); end
    end
    tests++;
    if (glog.size() != 2 || glog[0] != 1 || glog[1] != 3) begin
      fails++; $display("FAIL simul_order n=%0d first=%0d want 1 then 3", glog.size(), glog.size() ? glog[0] : -1);
    end
  endtask

  task automatic test_no_preempt();
    logic [OW-1:0] o, e;
    reset_dut();
    load(2, 6); drive_inputs();
    for (int c = 0; c < 3; c++) begin
      step(o, e); tests++;
      if (o !== e) begin fails++; $display("FAIL preempt_pre cyc%0d obs=%h exp=%h", c, o, e); end
    end
    load(0, 4); drive_inputs();
    for (int c = 0; c < LIMIT && !all_idle(); c++) begin
      step(o, e); tests++;
      if (o !== e) begin fails++; $display("FAIL preempt cyc%0d obs=%h exp=%h", c, o, e); end
    end
    tests++;
    if (glog.size() != 2 || glog[0] != 2 || glog[1] != 0) begin
      fails++; $display("FAIL preempt_order n=%0d want 2 then 0", glog.size());
    end
  endtask

  task automatic test_reset_midgrant();
    logic [OW-1:0] o, e;
    reset_dut();
    load(1, 10); drive_inputs();
    for (int c = 0; c < 4; c++) begin
      step(o, e); tests++;
      if (o !== e) begin fails++; $display("FAIL midrst_pre cyc%0d obs=%h exp=%h", c, o, e); end
    end
    resetn = 1'b0;
    step(o, e);
    resetn = 1'b1;
    for (int i = 0; i < N; i++) cq[i].delete();
    drive_inputs();
    step(o, e); tests++;
    if (o[OW-1 -: N+2] !== '0) begin fails++; $display("FAIL midrst_state obs=%h exp=0", o[OW-1 -: N+2]); end
    glog.delete();
    for (int i = 0; i < N; i++) load(i, 3);
    drive_inputs();
    for (int c = 0; c < LIMIT && !all_idle(); c++) begin
      step(o, e); tests++;
      if (o !== e) begin fails++; $display("FAIL midrst cyc%0d obs=%h exp=%h", c, o, e); end
    end
    tests++;
    if (glog.size() != 4 || glog[0] != 0 || glog[1] != 1 || glog[2] != 2 || glog[3] != 3) begin
      fails++; $display("FAIL midrst_order n=%0d want 0,1,2,3", glog.size());
    end
  endtask

  task automatic test_write_gap();
    logic [OW-1:0] o, e;
    reset_dut();
    load(3, 10);
    for (int k = 3; k <= 5; k++) cq[3][k].w = 1'b0;
    drive_inputs();
    for (int c = 0; c < LIMIT && !all_idle(); c++) begin
      step(o, e); tests++;
      if (o !== e) begin fails++; $display("FAIL wgap cyc%0d obs=%h exp=%h", c, o, e); end
    end
    tests++;
    if (plots != 7) begin fails++; $display("FAIL wgap_plots got=%0d want=7", plots); end
    tests++;
    if (glog.size() != 1 || glog[0] != 3) begin fails++; $display("FAIL wgap_grant n=%0d want one grant to 3", glog.size()); end
  endtask

  task automatic test_random();
    logic [OW-1:0] o, e;
    reset_dut();
    for (int c = 0; c < 2000; c++) begin
      if ($urandom_range(0, 7) == 0) load($urandom_range(0, N-1), $urandom_range(1, 12));
      if ($urandom_range(0, 63) == 0) cq[$urandom_range(0, N-1)].delete();
      if (cq[0].size() > 0 && $urandom_range(0, 3) == 0) cq[0][0].w = 1'b0;
      resetn = ($urandom_range(0, 199) != 0);
      drive_inputs();
      step(o, e); tests++;
      if (o !== e) begin fails++; $display("FAIL random cyc%0d obs=%h exp=%h", c, o, e); end
    end
    resetn = 1'b1;
    for (int c = 0; c < LIMIT && !all_idle(); c++) begin
      step(o, e); tests++;
      if (o !== e) begin fails++; $display("FAIL rdrain cyc%0d obs=%h exp=%h", c, o, e); end
    end
    tests++;
    if (!all_idle()) begin fails++; $display("FAIL random_drain still busy after %0d cycles", LIMIT); end
  endtask

`ifdef DRAW_ARB_TIMEOUT_EN
  task automatic test_timeout();
    logic [OW-1:0] o, e;
    reset_dut();
    load(0, 20); load(1, 20); drive_inputs();
    for (int c = 0; c < LIMIT && !all_idle(); c++) begin
      step(o, e); tests++;
      if (o !== e) begin fails++; $display("FAIL timeout cyc%0d obs=%h exp=%h", c, o, e); end
    end
    tests++;
    if (glog.size() != 6 || glog[0] != 0 || glog[1] != 1 || glog[2] != 0 ||
        glog[3] != 1 || glog[4] != 0 || glog[5] != 1) begin
      fails++; $display("FAIL timeout_order n=%0d want 0,1,0,1,0,1", glog.size());
    end
  endtask
`endif

  initial begin
    resetn = 1'b0;
    m_owner = -1; m_last = 3; m_cut = 0; m_cnt = 0;
    m_x = '0; m_y = '0; m_c = '0; m_plot = 1'b0;
    drive_inputs();
    @(posedge clk); #1;
    test_reset();
    test_single_stream();
    test_simultaneous();
    test_no_preempt();
    test_reset_midgrant();
    test_write_gap();
    test_random();
`ifdef DRAW_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
